// File: rtl/multicycle_ctrl_if.sv
// Control-path bundle between the multicycle controller and its datapath/memory.
// The controller side uses the master modport; the datapath side uses slave.
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal;
    logic       timeout;
    logic [3:0] state;

    modport master (
        input  op, zero, mem_ready,
        output pc_en, pc_src, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, instr_done, illegal, timeout, state
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_en, pc_src, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, instr_done, illegal, timeout, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM with memory-wait timeout and sticky fault flags.
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4 on mem_ready
// DECODE | decode op, precompute branch target
// MEMADR | compute load/store address
// MEMRD  | load data read, wait for mem_ready
// MEMWB  | load write-back
// MEMWR  | store write, wait for mem_ready
// RTEX   | R-type ALU operation
// RTWB   | R-type write-back
// BEQ    | compare, branch if zero
// SLTIEX | slti compare against immediate
// SLTIWB | slti write-back
// TRAP   | fault, idle until reset
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQ    = 4'd8,
        S_SLTIEX = 4'd9,
        S_SLTIWB = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_wait_cnt;
    logic          r_illegal;
    logic          r_timeout;

    logic       w_wait_st;
    logic       w_expired;
    logic       w_set_illegal;
    logic       w_set_timeout;
    logic       w_pc_en;
    logic [1:0] w_pc_src;
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic       w_instr_done;

    assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    // Expires on the MEM_TIMEOUT-th waiting cycle; a late mem_ready still wins.
    assign w_expired = w_wait_st && !bus.mem_ready && (r_wait_cnt == CW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_illegal  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_illegal <= r_illegal | w_set_illegal;
            r_timeout <= r_timeout | w_set_timeout;
            if (!w_wait_st || bus.mem_ready || (w_state_nxt != r_state))
                r_wait_cnt <= '0;
            else
                r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        w_pc_en       = 1'b0;
        w_pc_src      = 2'b00;
        w_iord        = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_reg_dst     = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_reg_write   = 1'b0;
        w_alu_src_a   = 1'b0;
        w_alu_src_b   = 2'b00;
        w_alu_op      = 2'b00;
        w_instr_done  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    w_ir_write  = 1'b1;
                    w_pc_en     = 1'b1;
                    w_state_nxt = S_DECODE;
                end else if (w_expired) begin
                    w_set_timeout = 1'b1;
                    w_state_nxt   = S_TRAP;
                end
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: w_state_nxt = S_MEMADR;
                    OP_RT:        w_state_nxt = S_RTEX;
                    OP_BEQ:       w_state_nxt = S_BEQ;
                    OP_SLTI:      w_state_nxt = S_SLTIEX;
                    default: begin
                        w_set_illegal = 1'b1;
                        w_state_nxt   = S_TRAP;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_state_nxt = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
                if (bus.mem_ready) begin
                    w_state_nxt = S_MEMWB;
                end else if (w_expired) begin
                    w_set_timeout = 1'b1;
                    w_state_nxt   = S_TRAP;
                end
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_instr_done = 1'b1;
                w_state_nxt  = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                if (bus.mem_ready) begin
                    w_instr_done = 1'b1;
                    w_state_nxt  = S_FETCH;
                end else if (w_expired) begin
                    w_set_timeout = 1'b1;
                    w_state_nxt   = S_TRAP;
                end
            end
            S_RTEX: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
                w_state_nxt = S_RTWB;
            end
            S_RTWB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = 1'b1;
                w_instr_done = 1'b1;
                w_state_nxt  = S_FETCH;
            end
            S_BEQ: begin
                w_alu_src_a  = 1'b1;
                w_alu_op     = 2'b01;
                w_pc_src     = 2'b01;
                w_pc_en      = bus.zero;
                w_instr_done = 1'b1;
                w_state_nxt  = S_FETCH;
            end
            S_SLTIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu_op    = 2'b11;
                w_state_nxt = S_SLTIWB;
            end
            S_SLTIWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_state_nxt  = S_FETCH;
            end
            S_TRAP:  w_state_nxt = S_TRAP;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Enables and strobes are gated by rst_n so nothing commits while reset is held.
    assign bus.pc_en      = w_pc_en      & rst_n;
    assign bus.ir_write   = w_ir_write   & rst_n;
    assign bus.reg_write  = w_reg_write  & rst_n;
    assign bus.mem_read   = w_mem_read   & rst_n;
    assign bus.mem_write  = w_mem_write  & rst_n;
    assign bus.instr_done = w_instr_done & rst_n;
    assign bus.pc_src     = w_pc_src;
    assign bus.iord       = w_iord;
    assign bus.reg_dst    = w_reg_dst;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.alu_op     = w_alu_op;
    assign bus.illegal    = r_illegal;
    assign bus.timeout    = r_timeout;
    assign bus.state      = r_state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: expected per-cycle traces are built from each
// instruction's phase list and wait counts, then compared cycle by cycle.
module tb_multicycle_ctrl;
    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                           MEMWB = 4'd4, MEMWR = 4'd5, RTEX = 4'd6, RTWB = 4'd7,
                           BEQ = 4'd8, SLTIEX = 4'd9, SLTIWB = 4'd10, TRAP = 4'd11;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_RT = 6'b000000,
                           OP_BEQ = 6'b000100, OP_SLTI = 6'b001010;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    multicycle_ctrl_if bus_if();

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] get_ctrl();
        return {bus_if.pc_en, bus_if.pc_src, bus_if.iord, bus_if.mem_read, bus_if.mem_write,
                bus_if.ir_write, bus_if.reg_dst, bus_if.mem_to_reg, bus_if.reg_write,
                bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op, bus_if.instr_done};
    endfunction

    // Control word each state should present, straight from the state descriptions.
    function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr, input logic z);
        logic pe, io, mrd, mw, irw, rd, m2r, rw, asa, idn;
        logic [1:0] ps, asb, aop;
        {pe, io, mrd, mw, irw, rd, m2r, rw, asa, idn} = '0;
        ps = 2'b00; asb = 2'b00; aop = 2'b00;
        case (st)
            FETCH:  begin mrd = 1; asb = 2'b01; pe = mr; irw = mr; end
            DECODE: asb = 2'b11;
            MEMADR: begin asa = 1; asb = 2'b10; end
            MEMRD:  begin mrd = 1; io = 1; end
            MEMWB:  begin rw = 1; m2r = 1; idn = 1; end
            MEMWR:  begin mw = 1; io = 1; idn = mr; end
            RTEX:   begin asa = 1; aop = 2'b10; end
            RTWB:   begin rw = 1; rd = 1; idn = 1; end
            BEQ:    begin asa = 1; aop = 2'b01; ps = 2'b01; pe = z; idn = 1; end
            SLTIEX: begin asa = 1; asb = 2'b10; aop = 2'b11; end
            SLTIWB: begin rw = 1; idn = 1; end
            default: ;
        endcase
        return {pe, ps, io, mrd, mw, irw, rd, m2r, rw, asa, asb, aop, idn};
    endfunction

    task automatic step(input logic [3:0] est, input logic mr, input logic z,
                        input logic eill, input logic etmo);
        bus_if.mem_ready = mr;
        bus_if.zero      = z;
        #1;
        check("state", 32'(bus_if.state), 32'(est));
        check("ctrl", 32'(get_ctrl()), 32'(exp_ctrl(est, mr, z)));
        check("flags", 32'({bus_if.illegal, bus_if.timeout}), 32'({eill, etmo}));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_if.mem_ready = 1'($urandom_range(0, 1));
        #1;
        check("rst_state", 32'(bus_if.state), 32'(FETCH));
        check("rst_strobes", 32'({bus_if.pc_en, bus_if.ir_write, bus_if.reg_write,
                                  bus_if.mem_read, bus_if.mem_write, bus_if.instr_done}), 32'd0);
        check("rst_flags", 32'({bus_if.illegal, bus_if.timeout}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Phase list of one instruction: fw/mw are memory wait cycles before mem_ready.
    task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
        logic [4:0] q[$];
        logic       r;
        bus_if.op = op;
        repeat (fw) q.push_back({FETCH, 1'b0});
        q.push_back({FETCH, 1'b1});
        q.push_back({DECODE, 1'($urandom_range(0, 1))});
        case (op)
            OP_LW: begin
                q.push_back({MEMADR, 1'($urandom_range(0, 1))});
                repeat (mw) q.push_back({MEMRD, 1'b0});
                q.push_back({MEMRD, 1'b1});
                q.push_back({MEMWB, 1'($urandom_range(0, 1))});
            end
            OP_SW: begin
                q.push_back({MEMADR, 1'($urandom_range(0, 1))});
                repeat (mw) q.push_back({MEMWR, 1'b0});
                q.push_back({MEMWR, 1'b1});
            end
            OP_RT: begin
                q.push_back({RTEX, 1'($urandom_range(0, 1))});
                q.push_back({RTWB, 1'($urandom_range(0, 1))});
            end
            OP_BEQ:  q.push_back({BEQ, 1'($urandom_range(0, 1))});
            OP_SLTI: begin
                q.push_back({SLTIEX, 1'($urandom_range(0, 1))});
                q.push_back({SLTIWB, 1'($urandom_range(0, 1))});
            end
            default: begin
                for (int i = 0; i < 3; i++) q.push_back({TRAP, 1'($urandom_range(0, 1))});
            end
        endcase
        foreach (q[i]) begin
            r = q[i][0];
            step(q[i][4:1], r, z, q[i][4:1] == TRAP, 1'b0);
        end
    endtask

    initial begin
        logic [5:0] op;
        int         sel;
        int         fw;
        int         mw;
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        bus_if.op = OP_RT;
        bus_if.zero = 1'b0;
        bus_if.mem_ready = 1'b0;
        #2;
        do_reset();

        // Directed: lw, beq taken / not taken, sw with waits, slti, R-type.
        run_instr(OP_LW, 1'b0, 0, 0);
        run_instr(OP_BEQ, 1'b1, 0, 0);
        run_instr(OP_BEQ, 1'b0, 0, 0);
        run_instr(OP_SW, 1'b0, 0, 3);
        run_instr(OP_SLTI, 1'b0, 0, 0);
        run_instr(OP_RT, 1'b1, 0, 0);

        // Illegal opcode traps on the third cycle and holds until reset.
        run_instr(6'b111111, 1'b0, 0, 0);
        do_reset();
        run_instr(OP_RT, 1'b0, 0, 0);

        // Fetch timeout: fifteen waiting cycles with no mem_ready.
        bus_if.op = OP_RT;
        for (int i = 0; i < 15; i++) step(FETCH, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(TRAP, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
        do_reset();
        // mem_ready on the fifteenth waiting cycle is honoured.
        run_instr(OP_RT, 1'b0, 14, 0);
        run_instr(OP_LW, 1'b0, 0, 14);

        // Reset during RTWB kills the write-back immediately.
        bus_if.op = OP_RT;
        step(FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
        step(DECODE, 1'b1, 1'b0, 1'b0, 1'b0);
        step(RTEX, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("rtwb_state", 32'(bus_if.state), 32'(RTWB));
        check("rtwb_regw", 32'(bus_if.reg_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_regw", 32'(bus_if.reg_write), 32'd0);
        check("rst_done", 32'(bus_if.instr_done), 32'd0);
        check("rst_st", 32'(bus_if.state), 32'(FETCH));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_instr(OP_SLTI, 1'b0, 0, 0);

        // Random instruction stream.
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 10));
            case (sel)
                0, 1: op = OP_LW;
                2, 3: op = OP_SW;
                4, 5: op = OP_RT;
                6, 7: op = OP_BEQ;
                8, 9: op = OP_SLTI;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    while (op == OP_LW || op == OP_SW || op == OP_RT ||
                           op == OP_BEQ || op == OP_SLTI)
                        op = 6'($urandom_range(0, 63));
                end
            endcase
            fw = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
            run_instr(op, 1'($urandom_range(0, 1)), fw, mw);
            if (sel == 10) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
